// File: rtl/mem_test_pkg.sv
// Shared definitions for the memory-test responder.
//   state_e              : responder FSM states
//   DEFAULT_*_LATENCY    : default request-to-ack latencies in cycles
//   MIN_LATENCY          : smallest legal latency, checked at elaboration
package mem_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_ACK,
        RD_WAIT,
        RD_ACK
    } state_e;

    localparam int DEFAULT_WRITE_LATENCY = 2;
    localparam int DEFAULT_READ_LATENCY  = 3;
    localparam int MIN_LATENCY           = 1;

endpackage

// File: rtl/mem_test_ram.sv
// Storage array behind the memory-test responder.
// Single port: synchronous write, asynchronous read, no reset on contents.
// Ports:
//   i_clk    in  1            clock
//   i_we     in  1            write enable (commits at the rising edge)
//   i_addr   in  ADDR_WIDTH   shared read/write address
//   i_wdata  in  DATUM_WIDTH  write data
//   o_rdata  out DATUM_WIDTH  combinational read data at i_addr
module mem_test_ram
    import mem_test_pkg::*;
#(
    parameter int DATUM_WIDTH = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 256
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic [DATUM_WIDTH-1:0] i_wdata,
    output logic [DATUM_WIDTH-1:0] o_rdata
);

    logic [DATUM_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

    // Caller guarantees i_addr < DEPTH whenever o_rdata is consumed.
    assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/mem_test_responder.sv
// Memory target answering a memory tester's write/read requests through a
// request/acknowledge handshake with configurable latency.
// Optional feature macro: MEM_TEST_RESPONDER_FAULT_INJECT_EN -- when defined,
// reads of FAULT_ADDR return the stored word XORed with FAULT_MASK.
// Ports:
//   i_clk                 in  1            clock
//   i_rst_n               in  1            synchronous active-low reset
//   i_write_req           in  1            write request, held until write_ready
//   i_read_req            in  1            read request, held until read_valid
//   i_address             in  ADDR_WIDTH   word address
//   i_memory_data_write   in  DATUM_WIDTH  write data
//   o_memory_write_ready  out 1            one-cycle pulse: write committed
//   o_memory_read_valid   out 1            one-cycle pulse: read data valid
//   o_memory_data_read    out DATUM_WIDTH  read data, held until next read ack
//   o_busy                out 1            high whenever not IDLE
//   o_addr_error          out 1            pulse with the ack for address >= DEPTH
module mem_test_responder
    import mem_test_pkg::*;
#(
    parameter int DATUM_WIDTH   = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int DEPTH         = 256,
    parameter int WRITE_LATENCY = DEFAULT_WRITE_LATENCY,
    parameter int READ_LATENCY  = DEFAULT_READ_LATENCY,
    parameter int FAULT_ADDR    = 0,
    parameter int FAULT_MASK    = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_write_req,
    input  logic                   i_read_req,
    input  logic [ADDR_WIDTH-1:0]  i_address,
    input  logic [DATUM_WIDTH-1:0] i_memory_data_write,
    output logic                   o_memory_write_ready,
    output logic                   o_memory_read_valid,
    output logic [DATUM_WIDTH-1:0] o_memory_data_read,
    output logic                   o_busy,
    output logic                   o_addr_error
);

    localparam int MAX_LAT = (WRITE_LATENCY > READ_LATENCY) ? WRITE_LATENCY : READ_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0]      WR_LOAD   = CNT_W'(WRITE_LATENCY - 1);
    localparam logic [CNT_W-1:0]      RD_LOAD   = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    if (WRITE_LATENCY < MIN_LATENCY || READ_LATENCY < MIN_LATENCY) begin : g_bad_latency
        $error("mem_test_responder: latencies must be >= %0d", MIN_LATENCY);
    end
    if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $error("mem_test_responder: DEPTH exceeds address space");
    end
    if (FAULT_ADDR >= (2 ** ADDR_WIDTH) || FAULT_MASK >= (2 ** DATUM_WIDTH)) begin : g_bad_fault
        $error("mem_test_responder: FAULT_ADDR/FAULT_MASK out of range");
    end

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATUM_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATUM_WIDTH-1:0] rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic [DATUM_WIDTH-1:0] ram_rdata;
    logic [DATUM_WIDTH-1:0] fault_xor;
    logic [DATUM_WIDTH-1:0] rd_word;
    logic                   addr_ok;
    logic                   ram_we;

    // In IDLE the array is addressed straight from the request so that a
    // latency-1 read can load its data on the capture edge; afterwards the
    // latched address is used so later changes on i_address are ignored.
    assign ram_addr = (state_q == IDLE) ? i_address : addr_q;
    assign addr_ok  = ({1'b0, ram_addr} < DEPTH_LIM);

    // Reset at the commit edge aborts the write.
    assign ram_we   = (state_q == WR_ACK) && addr_ok && i_rst_n;

`ifdef MEM_TEST_RESPONDER_FAULT_INJECT_EN
    assign fault_xor = (ram_addr == ADDR_WIDTH'(FAULT_ADDR)) ? DATUM_WIDTH'(FAULT_MASK) : '0;
`else
    assign fault_xor = '0;
`endif

    assign rd_word = addr_ok ? (ram_rdata ^ fault_xor) : '0;

    mem_test_ram #(
        .DATUM_WIDTH (DATUM_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DEPTH       (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_addr  (ram_addr),
        .i_wdata (wdata_q),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                // Write has priority; a simultaneous read stays asserted and
                // is captured in the IDLE cycle after the write completes.
                if (i_write_req) begin
                    addr_d  = i_address;
                    wdata_d = i_memory_data_write;
                    cnt_d   = WR_LOAD;
                    state_d = (WRITE_LATENCY == 1) ? WR_ACK : WR_WAIT;
                end else if (i_read_req) begin
                    addr_d  = i_address;
                    cnt_d   = RD_LOAD;
                    if (READ_LATENCY == 1) begin
                        state_d = RD_ACK;
                        rdata_d = rd_word;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            // The counter holds the number of WAIT cycles still to run, so the
            // ack lands exactly LATENCY cycles after the capture edge.
            WR_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = WR_ACK;
                end
            end
            WR_ACK: begin
                state_d = IDLE;
            end
            RD_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = RD_ACK;
                    rdata_d = rd_word;
                end
            end
            RD_ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Request payload registers carry no reset; they are only consumed after
    // a capture has loaded them.
    always_ff @(posedge i_clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign o_memory_write_ready = (state_q == WR_ACK);
    assign o_memory_read_valid  = (state_q == RD_ACK);
    assign o_memory_data_read   = rdata_q;
    assign o_busy               = (state_q != IDLE);
    assign o_addr_error         = ((state_q == WR_ACK) || (state_q == RD_ACK)) && !addr_ok;

endmodule

// File: tb/tb_mem_test_responder.sv
// Bench for mem_test_responder. DUT "a": DEPTH=200, latencies 2/3.
// DUT "b": DEPTH=256, latencies 1/1, FAULT_ADDR=0x07, FAULT_MASK=0x01.
module tb_mem_test_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n, a_wr_req, a_rd_req;
    logic [7:0] a_addr, a_wdata, a_rdata;
    logic       a_wr_rdy, a_rd_vld, a_busy, a_err;

    logic       b_rst_n, b_wr_req, b_rd_req;
    logic [7:0] b_addr, b_wdata, b_rdata;
    logic       b_wr_rdy, b_rd_vld, b_busy, b_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_test_responder #(
        .DATUM_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200),
        .WRITE_LATENCY(2), .READ_LATENCY(3), .FAULT_ADDR(0), .FAULT_MASK(1)
    ) dut_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_write_req(a_wr_req), .i_read_req(a_rd_req),
        .i_address(a_addr), .i_memory_data_write(a_wdata),
        .o_memory_write_ready(a_wr_rdy), .o_memory_read_valid(a_rd_vld),
        .o_memory_data_read(a_rdata), .o_busy(a_busy), .o_addr_error(a_err)
    );

    mem_test_responder #(
        .DATUM_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256),
        .WRITE_LATENCY(1), .READ_LATENCY(1), .FAULT_ADDR(7), .FAULT_MASK(1)
    ) dut_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_write_req(b_wr_req), .i_read_req(b_rd_req),
        .i_address(b_addr), .i_memory_data_write(b_wdata),
        .o_memory_write_ready(b_wr_rdy), .o_memory_read_valid(b_rd_vld),
        .o_memory_data_read(b_rdata), .o_busy(b_busy), .o_addr_error(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one write; lat = cycles from capture edge to write_ready (-1 on timeout).
    task automatic bus_write(input int sel, input logic [7:0] addr, input logic [7:0] data,
                             output int lat, output logic err);
        lat = -1;
        err = 1'b0;
        if (sel == 0) begin a_addr = addr; a_wdata = data; a_wr_req = 1'b1; end
        else          begin b_addr = addr; b_wdata = data; b_wr_req = 1'b1; end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (((sel == 0) ? a_wr_rdy : b_wr_rdy) === 1'b1) begin
                lat = i;
                err = (sel == 0) ? a_err : b_err;
                break;
            end
            // Perturb payload after capture; the responder must ignore it.
            if (sel == 0) begin a_addr = ~addr; a_wdata = ~data; end
            else          begin b_addr = ~addr; b_wdata = ~data; end
        end
        if (sel == 0) a_wr_req = 1'b0; else b_wr_req = 1'b0;
        tick();
    endtask

    task automatic bus_read(input int sel, input logic [7:0] addr,
                            output int lat, output logic err, output logic [7:0] data);
        lat  = -1;
        err  = 1'b0;
        data = 8'hxx;
        if (sel == 0) begin a_addr = addr; a_rd_req = 1'b1; end
        else          begin b_addr = addr; b_rd_req = 1'b1; end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (((sel == 0) ? a_rd_vld : b_rd_vld) === 1'b1) begin
                lat  = i;
                err  = (sel == 0) ? a_err : b_err;
                data = (sel == 0) ? a_rdata : b_rdata;
                break;
            end
            if (sel == 0) a_addr = ~addr; else b_addr = ~addr;
        end
        if (sel == 0) a_rd_req = 1'b0; else b_rd_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        tick(); tick();
        n_checks++; if (a_wr_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", a_wr_rdy); end
        n_checks++; if (a_rd_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", a_rd_vld); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_error: got %b want 0", a_err); end
        n_checks++; if (a_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_data_read: got %h want 00", a_rdata); end
        n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        int lat; logic err; logic [7:0] d;
        bus_write(0, 8'h10, 8'hA5, lat, err);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d want 2", lat); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_addr_error: got %b want 0", err); end
        bus_read(0, 8'h10, lat, err, d);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lat); end
        n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h want a5", d); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd_addr_error: got %b want 0", err); end
        n_checks++; if (a_rd_vld !== 1'b0) begin n_fail++; $display("FAIL rd_valid_pulse: got %b want 0", a_rd_vld); end
        n_checks++; if (a_rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_data_hold: got %h want a5", a_rdata); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", a_busy); end
    endtask

    task automatic test_simultaneous();
        int lat; logic saw_vld; logic [7:0] d;
        lat = -1; saw_vld = 1'b0; d = 8'h00;
        a_addr = 8'h20; a_wdata = 8'h3C; a_wr_req = 1'b1; a_rd_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) begin
                n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL sim_busy_wait: got %b want 1", a_busy); end
            end
            if (a_rd_vld === 1'b1) saw_vld = 1'b1;
            if (a_wr_rdy === 1'b1) begin lat = i; break; end
        end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sim_wr_latency: got %0d want 2", lat); end
        n_checks++; if (saw_vld !== 1'b0) begin n_fail++; $display("FAIL sim_read_first: got %b want 0", saw_vld); end
        a_wr_req = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (a_rd_vld === 1'b1) begin lat = i; d = a_rdata; break; end
        end
        // ack->IDLE, capture, two waits, then read ack.
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL sim_rd_latency: got %0d want 4", lat); end
        n_checks++; if (d !== 8'h3C) begin n_fail++; $display("FAIL sim_rd_data: got %h want 3c", d); end
        a_rd_req = 1'b0;
        tick();
    endtask

    task automatic test_addr_error();
        int lat; logic err; logic [7:0] d;
        bus_write(0, 8'hF0, 8'hFF, lat, err);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL oor_wr_latency: got %0d want 2", lat); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_error: got %b want 1", err); end
        bus_read(0, 8'hF0, lat, err, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL oor_rd_data: got %h want 00", d); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_rd_error: got %b want 1", err); end
        bus_write(0, 8'hC7, 8'h77, lat, err);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL last_wr_error: got %b want 0", err); end
        bus_read(0, 8'hC7, lat, err, d);
        n_checks++; if (d !== 8'h77) begin n_fail++; $display("FAIL last_rd_data: got %h want 77", d); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL last_rd_error: got %b want 0", err); end
        bus_read(0, 8'hC8, lat, err, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL depth_rd_data: got %h want 00", d); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL depth_rd_error: got %b want 1", err); end
    endtask

    task automatic test_reset_mid();
        int lat; logic err; logic [7:0] d; logic saw;
        bus_write(0, 8'h05, 8'h11, lat, err);
        bus_read(0, 8'h10, lat, err, d);
        n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL pre_abort_rd: got %h want a5", d); end
        a_addr = 8'h05; a_wdata = 8'h55; a_wr_req = 1'b1;
        tick();
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_wait: got %b want 1", a_busy); end
        a_rst_n = 1'b0; a_wr_req = 1'b0;
        tick();
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", a_busy); end
        n_checks++; if (a_rdata !== 8'h00) begin n_fail++; $display("FAIL abort_data_read: got %h want 00", a_rdata); end
        a_rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (a_wr_rdy !== 1'b0) saw = 1'b1;
        end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_ack: got %b want 0", saw); end
        bus_read(0, 8'h05, lat, err, d);
        n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL abort_not_committed: got %h want 11", d); end
    endtask

    task automatic test_back_to_back();
        int lat; logic err; logic [7:0] d; logic exp;
        b_addr = 8'h30; b_wdata = 8'h99; b_wr_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = (i % 2) == 1;
            n_checks++; if (b_wr_rdy !== exp) begin n_fail++; $display("FAIL b2b_ready cycle %0d: got %b want %b", i, b_wr_rdy, exp); end
            n_checks++; if (b_busy !== exp) begin n_fail++; $display("FAIL b2b_busy cycle %0d: got %b want %b", i, b_busy, exp); end
        end
        b_wr_req = 1'b0;
        tick();
        bus_read(1, 8'h30, lat, err, d);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL b2b_rd_latency: got %0d want 1", lat); end
        n_checks++; if (d !== 8'h99) begin n_fail++; $display("FAIL b2b_rd_data: got %h want 99", d); end
    endtask

    task automatic test_fault();
        int lat; logic err; logic [7:0] d; logic [7:0] exp7;
`ifdef MEM_TEST_RESPONDER_FAULT_INJECT_EN
        exp7 = 8'h41;
`else
        exp7 = 8'h40;
`endif
        bus_write(1, 8'h07, 8'h40, lat, err);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL fault_wr_latency: got %0d want 1", lat); end
        bus_write(1, 8'h08, 8'h40, lat, err);
        bus_read(1, 8'h07, lat, err, d);
        n_checks++; if (d !== exp7) begin n_fail++; $display("FAIL fault_rd_07: got %h want %h", d, exp7); end
        bus_read(1, 8'h08, lat, err, d);
        n_checks++; if (d !== 8'h40) begin n_fail++; $display("FAIL fault_rd_08: got %h want 40", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        a_rst_n = 1'b0; a_wr_req = 1'b0; a_rd_req = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
        b_rst_n = 1'b0; b_wr_req = 1'b0; b_rd_req = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
        test_reset();
        test_write_read();
        test_simultaneous();
        test_addr_error();
        test_reset_mid();
        test_back_to_back();
        test_fault();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_test_responder.md
Name: mem_test_responder

Overview:
- Memory target that sits on the far side of the memory-test interface and answers the memory tester's write and read requests.
- Holds a DEPTH x DATUM_WIDTH storage array behind a request/acknowledge handshake with configurable write and read latency.
- Serves as the tester's simulation partner and as a synthesizable on-chip test memory.
- An optional fault injector corrupts one location so that the tester's error path can be exercised.

Parameters:
- DATUM_WIDTH, 8, data word width in bits.
- ADDR_WIDTH, 8, address width in bits.
- DEPTH, 256, number of words; must be <= 2**ADDR_WIDTH.
- WRITE_LATENCY, 2, cycles from request capture to o_memory_write_ready; minimum 1.
- READ_LATENCY, 3, cycles from request capture to o_memory_read_valid; minimum 1.
- FAULT_ADDR, 0, faulted location; used only with the optional feature.
- FAULT_MASK, 1, XOR mask applied to read data at FAULT_ADDR; used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_write_req  in  1  write request; level held until o_memory_write_ready.
- i_read_req  in  1  read request; level held until o_memory_read_valid.
- i_address  in  ADDR_WIDTH  word address.
- i_memory_data_write  in  DATUM_WIDTH  write data from the tester.
- o_memory_write_ready  out  1  one-cycle pulse: write committed.
- o_memory_read_valid  out  1  one-cycle pulse: o_memory_data_read is valid.
- o_memory_data_read  out  DATUM_WIDTH  read data.
- o_busy  out  1  high in every state except IDLE.
- o_addr_error  out  1  one-cycle pulse, coincident with the ack, when i_address >= DEPTH.

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - State goes to IDLE and the latency counter clears.
  - o_memory_write_ready, o_memory_read_valid, o_busy, o_addr_error and o_memory_data_read all go to 0.
  - Array contents are not cleared.
- FSM states: IDLE, WR_WAIT, WR_ACK, RD_WAIT, RD_ACK.
- IDLE:
  - Requests are sampled only in IDLE.
  - i_write_req high: latch address and data, load the counter with WRITE_LATENCY-1, go to WR_WAIT.
  - Otherwise, i_read_req high: latch address, load the counter with READ_LATENCY-1, go to RD_WAIT.
  - Both requests high: write wins; the read stays pending and is served after the write completes.
- WR_WAIT: decrement the counter; at 0 go to WR_ACK.
- WR_ACK (one cycle):
  - Assert o_memory_write_ready.
  - Commit the write to the array at this clock edge, only if the latched address < DEPTH.
  - Then return to IDLE.
- RD_WAIT: decrement the counter; at 0 go to RD_ACK.
- RD_ACK (one cycle):
  - Assert o_memory_read_valid.
  - o_memory_data_read = array[latched address], or 0 if the address is out of range.
  - Return to IDLE.
- Latency: ack appears WRITE_LATENCY (resp. READ_LATENCY) cycles after the capture edge.
  - Latency 1 skips the WAIT state; the ack is on the next cycle.
- o_memory_data_read holds its value until the next RD_ACK.
- Request still high in IDLE after an ack: treated as a new transaction. The initiator deasserts on the ack cycle.
- Changes to i_address or i_memory_data_write after capture are ignored.
- Out-of-range address: write dropped, read returns 0, o_addr_error pulses with the ack.
- Reset mid-transaction: transaction aborted, pending write never committed, no ack issued.
- Read-after-write to the same address returns the new data; the commit precedes any later capture.
- Counter width: $clog2(max(WRITE_LATENCY, READ_LATENCY)+1).

Optional Feature:
- Macro MEM_TEST_RESPONDER_FAULT_INJECT_EN.
- Defined: reads of FAULT_ADDR return array[FAULT_ADDR] ^ FAULT_MASK. The stored value is unchanged, and writes are unaffected.
- Undefined: FAULT_ADDR and FAULT_MASK are unused; reads are exact.

Decomposition:
- Package mem_test_pkg:
  - Typedef enum of responder FSM states.
  - Default latency constants.
  - Minimum-latency constant used in elaboration assertions.
- Sub-module mem_test_ram:
  - Single-port synchronous-write, asynchronous-read array (DEPTH, DATUM_WIDTH).
  - Instantiated once; the responder owns the FSM, counter and fault XOR.

Test Plan:
- Reset, then write 0xA5 to address 0x10 (latencies 2/3) -> write_ready pulses 2 cycles after capture. A read of 0x10 -> read_valid 3 cycles after capture with data 0xA5.
- i_write_req and i_read_req rise together, address 0x20, data 0x3C -> write serviced first. The read is then captured in the next IDLE and returns 0x3C.
- DEPTH=200, write 0xFF to address 0xF0 -> write_ready and o_addr_error pulse together. A read of 0xF0 returns 0x00 with o_addr_error.
- i_rst_n low during WR_WAIT of a write 0x55 to 0x05 (previously 0x11) -> no write_ready pulse; a read of 0x05 returns 0x11.
- WRITE_LATENCY=1, READ_LATENCY=1, back-to-back held write requests -> ack every 2 cycles and o_busy toggles correctly.
- Macro defined, FAULT_ADDR=0x07, FAULT_MASK=0x01, write 0x40 to 0x07 -> read returns 0x41; a read of 0x08 after writing 0x40 returns 0x40.
